rs232_avalon_slave: RTL
=======================

// Module: rs232_avalon_slave
// PURPOSE
//  Avalon-MM slave emulating the RS232 UART register map polled by the wrapper masters: RX data @0x0, TX data @0x4, STATUS @0x8.
//  Serialises written TX bytes onto uart_txd and deserialises uart_rxd into a receive buffer, both 8N1, LSB first.
//  Sits between the system interconnect and the board RS232 pins; also serves as the bench-side partner for master-level testing.
// PARAMETERS
//  CLK_HZ         50000000  avm_clk frequency
//  BAUD           115200    line rate; DIV = CLK_HZ/BAUD clocks per bit (integer, >=4)
//  RX_FIFO_DEPTH  4         RX buffer entries when UART_RX_FIFO_EN is defined (power of 2)
// PORTS
//  avm_clk          in   1   clock
//  avm_rst          in   1   synchronous active-high reset
//  avs_address      in   5   byte address; decode on [3:2]: 0=RX, 1=TX, 2=STATUS, 3=reserved
//  avs_read         in   1   read request, held by master until avs_waitrequest=0
//  avs_readdata     out  32  read data, valid in the cycle avs_waitrequest=0 for a read
//  avs_write        in   1   write request, held by master until avs_waitrequest=0
//  avs_writedata    in   32  write data; only [7:0] used
//  avs_waitrequest  out  1   stall; combinational = (avs_read|avs_write) & ~ack_r
//  uart_rxd         in   1   serial in, asynchronous, idle high
//  uart_txd         out  1   serial out, idle high
// BEHAVIOUR
//  Clock is avm_clk; reset is synchronous, active-high on avm_rst; all state cleared on the edge where avm_rst=1.
//  Reset values: avs_readdata=0, ack_r=0, uart_txd=1, RX buffer empty, TX holding empty, sticky flags 0, both FSMs IDLE.
//  Handshake: request seen with ack_r=0 -> ack_r<=1 (wait cycle); next cycle waitrequest=0, access commits, ack_r<=0. Every access = 2 cycles.
//  read & write both high: write wins, readdata=0. Address change mid-wait not supported (master holds it).
//  STATUS read: [7]=RX_OK (buffer non-empty), [6]=TX_OK (holding reg empty), [8]=RX_OVR, [9]=TX_OVF, [10]=FRAME_ERR; rest 0.
//   Sticky [10:8] clear on the commit cycle of a STATUS read (returned value shows them set).
//  RX read: readdata={24'b0,head byte}; pops on commit. Empty -> returns 0, no pop, no flag.
//  TX write: if TX_OK, latch writedata[7:0], TX_OK falls on next edge; else byte dropped, TX_OVF<=1.
//  Reserved address: read 0, write ignored; handshake identical.
//  TX FSM IDLE->START->DATA(8)->STOP->IDLE; each state DIV clocks; leaves IDLE the cycle after holding reg loads;
//   holding reg freed (TX_OK=1) when START entered, so next byte may queue during a frame; back-to-back frames have no idle gap.
//  RX: 2-flop synchroniser; IDLE on falling edge -> START; sample at DIV/2: high -> IDLE (glitch reject), low -> DATA;
//   8 samples at DIV intervals, LSB first; STOP sample at DIV: 1 -> push byte, 0 -> discard + FRAME_ERR<=1. Back to IDLE.
//  Push and pop in same cycle: both occur, occupancy unchanged. Push when full: byte discarded, RX_OVR<=1, contents kept.
//  Baud counters: free-running per FSM, reload to 0 on state entry; width $clog2(DIV).
//  Reset mid-frame: uart_txd=1 the cycle after reset edge; partial RX frame discarded; no flags.
// CONFIGURATION
//  UART_RX_FIFO_EN defined: RX buffer = RX_FIFO_DEPTH-entry circular FIFO (rd/wr pointers + count).
//  Not defined: single holding register (depth 1); RX_OVR when a byte completes while RX_OK=1. Register map unchanged.
// STRUCTURE
//  Package rs232_pkg: RX_BASE=0, TX_BASE=4, STATUS_BASE=8, TX_OK_BIT=6, RX_OK_BIT=7, RX_OVR_BIT=8, TX_OVF_BIT=9,
//   FRAME_ERR_BIT=10, typedef enum {IDLE,START,DATA,STOP} uart_state_e.
//  Sub-module rs232_rx_deserializer: synchroniser + RX FSM, outputs byte, push strobe, frame_err strobe.
//  TX FSM, register decode, RX buffer in top.
// TESTING  (CLK_HZ=160, BAUD=10 -> DIV=16)
//  Reset, idle: STATUS read -> 0x40, waitrequest high 1 cycle then low, uart_txd=1 throughout.
//  Write 0xA5 @0x4 -> STATUS=0x00 next access; uart_txd: 16 clk low, bits 1,0,1,0,0,1,0,1 x16 each, 16 clk high; TX_OK=1 from start bit.
//  Drive 0x3C on uart_rxd -> STATUS bit7=1; read @0x0 -> 0x3C; next STATUS read -> 0x40.
//  Write 2 bytes back-to-back then a 3rd while busy -> 3rd dropped, STATUS=0x240 then 0x40 after read clears.
//  RX 0x11 with stop bit 0 -> no push, STATUS=0x440; 8-clk low glitch on uart_rxd -> nothing received.
//  FIFO_EN: send 5 bytes 0x01..0x05 unread -> reads 0x01..0x04, STATUS bit8=1; non-FIFO: 2 bytes -> reads 0x01, RX_OVR=1.

Source files
------------

// File: rtl/rs232_avalon_slave_pkg.sv
// rs232_pkg: register map offsets, STATUS bit positions and the UART FSM
// state type shared by rs232_avalon_slave and rs232_rx_deserializer.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'h0;
  localparam logic [4:0] TX_BASE     = 5'h4;
  localparam logic [4:0] STATUS_BASE = 5'h8;

  localparam int unsigned TX_OK_BIT     = 6;
  localparam int unsigned RX_OK_BIT     = 7;
  localparam int unsigned RX_OVR_BIT    = 8;
  localparam int unsigned TX_OVF_BIT    = 9;
  localparam int unsigned FRAME_ERR_BIT = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/rs232_avalon_slave_if.sv
// Avalon-MM slave bus bundle for rs232_avalon_slave.
// Signals: avs_address/read/write/writedata (master->slave), avs_readdata/waitrequest (slave->master).
interface rs232_avalon_slave_if;

  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );

endinterface

// File: rtl/rs232_rx_deserializer.sv
// 8N1 receiver: 2-flop synchroniser plus RX FSM with start-bit glitch reject.
// Ports: avm_clk, avm_rst (sync, active-high), uart_rxd in; rx_byte, rx_push, rx_ferr out.
module rs232_rx_deserializer
  import rs232_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       avm_clk,
  input  logic       avm_rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       rx_push,
  output logic       rx_ferr
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  uart_state_e   state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          s1, s2, prev;
  logic          tick;

  assign tick = cnt == LAST;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= uart_rxd;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || tick) ? '0 : cnt + 1'b1;
      if (state == START) begin
        idx <= '0;
      end else if (state == DATA && tick) begin
        sh  <= {s2, sh[7:1]};
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (prev & ~s2) state_n = START;
      START: if (cnt == HALF) state_n = s2 ? IDLE : DATA;
      DATA:  if (tick && idx == 3'd7) state_n = STOP;
      STOP:  if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rx_byte = sh;
    rx_push = 1'b0;
    rx_ferr = 1'b0;
    if (state == STOP && tick) begin
      rx_push = s2;
      rx_ferr = ~s2;
    end
  end

endmodule

// File: rtl/rs232_avalon_slave.sv
// RS232 UART Avalon-MM slave: RX @0x0, TX @0x4, STATUS @0x8; 8N1 TX FSM and RX buffer.
// Ports: avm_clk, avm_rst, avs (rs232_avalon_slave_if.slave), uart_rxd, uart_txd. Macro UART_RX_FIFO_EN.
module rs232_avalon_slave
  import rs232_pkg::*;
#(
  parameter int CLK_HZ        = 50000000,
  parameter int BAUD          = 115200,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                avm_clk,
  input  logic                avm_rst,
  rs232_avalon_slave_if.slave avs,
  input  logic                uart_rxd,
  output logic                uart_txd
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic        req, rd, wait_cyc, commit, ack_r;
  logic        is_rx, is_tx, is_st;
  logic [31:0] rd_data, status, readdata;
  logic        pop_ok_r, pop, st_clr;
  logic [7:0]  hold;
  logic        hold_full, tx_load;
  logic        rx_ovr, tx_ovf, frame_err;
  logic [7:0]  rx_byte, rx_head;
  logic        rx_push, rx_ferr, rx_ok, push_ok, ovr_set;
  logic        unused_bits;

  assign req      = avs.avs_read | avs.avs_write;
  assign rd       = avs.avs_read & ~avs.avs_write;
  assign wait_cyc = req & ~ack_r;
  assign commit   = req & ack_r;
  assign is_rx    = avs.avs_address[3:2] == RX_BASE[3:2];
  assign is_tx    = avs.avs_address[3:2] == TX_BASE[3:2];
  assign is_st    = avs.avs_address[3:2] == STATUS_BASE[3:2];
  assign pop      = commit & pop_ok_r;
  assign st_clr   = commit & rd & is_st;

  assign avs.avs_waitrequest = wait_cyc;
  assign avs.avs_readdata    = readdata;

  assign unused_bits = ^{avs.avs_writedata[31:8],
                         avs.avs_address[4],
                         avs.avs_address[1:0]};

  always_comb begin
    status                = '0;
    status[TX_OK_BIT]     = ~hold_full;
    status[RX_OK_BIT]     = rx_ok;
    status[RX_OVR_BIT]    = rx_ovr;
    status[TX_OVF_BIT]    = tx_ovf;
    status[FRAME_ERR_BIT] = frame_err;
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      rd & is_rx: rd_data = rx_ok ? {24'b0, rx_head} : '0;
      rd & is_st: rd_data = status;
      default:    rd_data = '0;
    endcase
  end

  // readdata is captured on the wait cycle; a STATUS commit clears only
  // the sticky bits that were actually returned to the master.
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      ack_r     <= 1'b0;
      readdata  <= '0;
      pop_ok_r  <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      rx_ovr    <= 1'b0;
      tx_ovf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ack_r <= wait_cyc;
      if (wait_cyc) begin
        readdata <= rd_data;
        pop_ok_r <= rd & is_rx & rx_ok;
      end
      if (tx_load) hold_full <= 1'b0;
      if (commit & avs.avs_write & is_tx) begin
        if (!hold_full) begin
          hold      <= avs.avs_writedata[7:0];
          hold_full <= 1'b1;
        end else begin
          tx_ovf <= 1'b1;
        end
      end
      rx_ovr    <= (rx_ovr & ~(st_clr & readdata[RX_OVR_BIT])) | ovr_set;
      frame_err <= (frame_err & ~(st_clr & readdata[FRAME_ERR_BIT])) | rx_ferr;
      if (st_clr & readdata[TX_OVF_BIT]) tx_ovf <= 1'b0;
    end
  end

  uart_state_e   tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_sh;
  logic          tx_tick;

  assign tx_tick = tx_cnt == LAST;
  assign tx_load = tx_state_n == START && tx_state != START;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= (tx_state_n != tx_state || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_load) begin
        tx_sh  <= hold;
        tx_idx <= '0;
      end else if (tx_state == DATA && tx_tick) begin
        tx_sh  <= {1'b0, tx_sh[7:1]};
        tx_idx <= tx_idx + 1'b1;
      end
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    unique case (tx_state)
      IDLE:  if (hold_full) tx_state_n = START;
      START: if (tx_tick) tx_state_n = DATA;
      DATA:  if (tx_tick && tx_idx == 3'd7) tx_state_n = STOP;
      STOP:  if (tx_tick) tx_state_n = hold_full ? START : IDLE;
      default: tx_state_n = IDLE;
    endcase
  end

  always_comb begin
    uart_txd = 1'b1;
    unique case (tx_state)
      START:   uart_txd = 1'b0;
      DATA:    uart_txd = tx_sh[0];
      default: uart_txd = 1'b1;
    endcase
  end

  rs232_rx_deserializer #(.DIV(DIV)) u_rx (
    .avm_clk  (avm_clk),
    .avm_rst  (avm_rst),
    .uart_rxd (uart_rxd),
    .rx_byte  (rx_byte),
    .rx_push  (rx_push),
    .rx_ferr  (rx_ferr)
  );

`ifdef UART_RX_FIFO_EN
  localparam int PW = $clog2(RX_FIFO_DEPTH);

  logic [7:0]    rx_mem [RX_FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0]   rx_cnt;
  logic          rx_full;

  assign rx_ok   = rx_cnt != '0;
  assign rx_full = rx_cnt == (PW + 1)'(RX_FIFO_DEPTH);
  assign rx_head = rx_mem[rp];
  assign push_ok = rx_push & (~rx_full | pop);
  assign ovr_set = rx_push & rx_full & ~pop;

  always_ff @(posedge avm_clk) begin
    if (push_ok) rx_mem[wp] <= rx_byte;
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      wp     <= '0;
      rp     <= '0;
      rx_cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      rx_cnt <= rx_cnt + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_full;
  logic       unused_depth;

  assign unused_depth = RX_FIFO_DEPTH[0];
  assign rx_ok   = rx_full;
  assign rx_head = rx_hold;
  assign push_ok = rx_push & (~rx_full | pop);
  assign ovr_set = rx_push & rx_full & ~pop;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      rx_hold <= '0;
      rx_full <= 1'b0;
    end else begin
      if (push_ok) rx_hold <= rx_byte;
      rx_full <= push_ok | (rx_full & ~pop);
    end
  end
`endif

endmodule
